data_bus_fifo_responder: RTL and testbench

DATA_BUS_FIFO_RESPONDER -- requirements
Module: data_bus_fifo_responder

---
 rtl/data_bus_fifo_responder_if.sv | 19 +
 rtl/data_bus_fifo_responder.sv | 121 ++++++++++++
 tb/tb_data_bus_fifo_responder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_fifo_responder_if.sv
// CPU data-bus slave port for the FIFO responder register window.
interface data_bus_fifo_responder_if;
    logic        DwReadEnable;
    logic        DwWriteEnable;
    logic [3:0]  DwByteEnable;
    logic [31:0] DwAddress;
    logic [31:0] DwWriteData;
    logic [31:0] DwReadData;

    modport master (
        output DwReadEnable, DwWriteEnable, DwByteEnable, DwAddress, DwWriteData,
        input  DwReadData
    );

    modport slave (
        input  DwReadEnable, DwWriteEnable, DwByteEnable, DwAddress, DwWriteData,
        output DwReadData
    );
endinterface

// File: rtl/data_bus_fifo_responder.sv
// Memory-mapped byte responder: RX FIFO drained over the data bus, single-entry TX
// holding register, sticky drop/overflow flags and a level IRQ on RX not empty.
module data_bus_fifo_responder #(
    parameter logic [31:0] BASE_ADDR = 32'hFF20_0000,
    parameter int          DEPTH     = 16
) (
    input  logic                          iCLK,
    input  logic                          iRST,
    data_bus_fifo_responder_if.slave      bus,
    input  logic [7:0]                    iRxData,
    input  logic                          iRxValid,
    output logic                          oRxReady,
    output logic [7:0]                    oTxData,
    output logic                          oTxValid,
    input  logic                          iTxReady,
    output logic                          oIrq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        OFF_RXDATA = 2'd0,
        OFF_STATUS = 2'd1,
        OFF_TXDATA = 2'd2,
        OFF_CTRL   = 2'd3
    } regOff_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [CW-1:0] count;
    logic          rxOvf, txDrop;

    logic          sel, empty, full;
    regOff_t       off;
    logic          push, pop, ovfSet;
    logic          txWr, txAccept, txDropSet;
    logic          flush, clrSticky;
    logic [31:0]   status, rdData;
    logic          unusedBits;

    assign sel   = (bus.DwAddress[31:4] == BASE_ADDR[31:4]);
    assign off   = regOff_t'(bus.DwAddress[3:2]);
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    assign oRxReady = ~full;
    assign oIrq     = ~empty;

    assign pop    = sel & bus.DwReadEnable & (off == OFF_RXDATA) & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the byte.
    assign push   = iRxValid & (~full | pop);
    assign ovfSet = iRxValid & full & ~pop;

    assign txWr      = sel & bus.DwWriteEnable & (off == OFF_TXDATA) & bus.DwByteEnable[0];
    assign txAccept  = txWr & (~oTxValid | iTxReady);
    assign txDropSet = txWr & oTxValid & ~iTxReady;

    assign flush     = sel & bus.DwWriteEnable & (off == OFF_CTRL) & bus.DwByteEnable[0]
                       & bus.DwWriteData[0];
    assign clrSticky = sel & bus.DwWriteEnable & (off == OFF_CTRL) & bus.DwByteEnable[0]
                       & bus.DwWriteData[1];

    assign status = {22'b0, txDrop, rxOvf, 6'(count), oTxValid, ~empty};

    always_comb begin
        rdData = '0;
        case (off)
            OFF_RXDATA: rdData = empty ? 32'h0 : {24'b0, mem[rdPtr]};
            OFF_STATUS: rdData = status;
            default:    rdData = '0;
        endcase
    end

    assign bus.DwReadData = (sel & bus.DwReadEnable) ? rdData : 32'hzzzz_zzzz;

    assign unusedBits = ^{bus.DwAddress[1:0], bus.DwWriteData[31:8], bus.DwByteEnable[3:1]};

    // Storage is not reset; only pointers and count define what is valid.
    always_ff @(posedge iCLK) begin
        if (push && !flush) mem[wrPtr] <= iRxData;
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + AW'(1);
            if (pop)  rdPtr <= rdPtr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            rxOvf  <= 1'b0;
            txDrop <= 1'b0;
        end else begin
            rxOvf  <= ovfSet    | (rxOvf  & ~clrSticky);
            txDrop <= txDropSet | (txDrop & ~clrSticky);
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oTxValid <= 1'b0;
            oTxData  <= '0;
        end else if (txAccept) begin
            oTxValid <= 1'b1;
            oTxData  <= bus.DwWriteData[7:0];
        end else if (oTxValid && iTxReady) begin
            oTxValid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_data_bus_fifo_responder.sv
// Directed bench: vector table for basic RX/TX/register behaviour plus hand sequences
// for full/overflow, out-of-window reads, flush, and asynchronous reset.
module tb_data_bus_fifo_responder;
    localparam logic [31:0] BASE = 32'hFF20_0000;
    localparam int          DEPTH = 16;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b0;
    logic [7:0] iRxData;
    logic       iRxValid;
    logic       oRxReady;
    logic [7:0] oTxData;
    logic       oTxValid;
    logic       iTxReady;
    logic       oIrq;

    int checks = 0;
    int errors = 0;

    data_bus_fifo_responder_if bus ();

    data_bus_fifo_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .bus      (bus),
        .iRxData  (iRxData),
        .iRxValid (iRxValid),
        .oRxReady (oRxReady),
        .oTxData  (oTxData),
        .oTxValid (oTxValid),
        .iTxReady (iTxReady),
        .oIrq     (oIrq)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        logic [3:0]  off;
        logic [31:0] wd;
        logic        rxV;
        logic [7:0]  rxD;
        logic        txR;
        logic        chkRd;
        logic [31:0] expRd;
        logic        expTxV;
        logic        chkTxD;
        logic [7:0]  expTxD;
        logic        expIrq;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // An undriven bus reads as z in a 4-state simulator and as 0 in a 2-state one;
    // either way it must not carry a register value.
    task automatic chkUndriven(input string name);
        checks++;
        if (bus.DwReadData !== 32'hzzzz_zzzz && bus.DwReadData !== 32'h0) begin
            errors++;
            $display("FAIL %s got=%h want=zzzzzzzz", name, bus.DwReadData);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [3:0] be,
                         input logic [3:0] off, input logic [31:0] wd,
                         input logic rxV, input logic [7:0] rxD, input logic txR);
        bus.DwReadEnable  = rd;
        bus.DwWriteEnable = wr;
        bus.DwByteEnable  = be;
        bus.DwAddress     = BASE + {28'b0, off};
        bus.DwWriteData   = wd;
        iRxValid          = rxV;
        iRxData           = rxD;
        iTxReady          = txR;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 8'h0, 1'b0);
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, d, 1'b0);
        tick();
    endtask

    task automatic readChk(input string name, input logic [3:0] off, input logic [31:0] exp);
        drive(1'b1, 1'b0, 4'h0, off, 32'h0, 1'b0, 8'h0, 1'b0);
        #1;
        chk(name, bus.DwReadData, exp);
        tick();
    endtask

    initial begin
        //              rd wr be    off   wd      rxV rxD  txR chk expRd   txV chkD txD  irq
        tbl[0]  = '{1'b0,1'b0,4'h0,4'h0,32'h0, 1'b1,8'h41,1'b0,1'b0,32'h0,  1'b0,1'b1,8'h00,1'b1};
        tbl[1]  = '{1'b0,1'b0,4'h0,4'h0,32'h0, 1'b1,8'h42,1'b0,1'b0,32'h0,  1'b0,1'b1,8'h00,1'b1};
        tbl[2]  = '{1'b0,1'b0,4'h0,4'h0,32'h0, 1'b1,8'h43,1'b0,1'b0,32'h0,  1'b0,1'b1,8'h00,1'b1};
        tbl[3]  = '{1'b1,1'b0,4'h0,4'h0,32'h0, 1'b0,8'h00,1'b0,1'b1,32'h41, 1'b0,1'b1,8'h00,1'b1};
        tbl[4]  = '{1'b1,1'b0,4'h0,4'h4,32'h0, 1'b0,8'h00,1'b0,1'b1,32'h09, 1'b0,1'b1,8'h00,1'b1};
        tbl[5]  = '{1'b1,1'b0,4'h0,4'h0,32'h0, 1'b0,8'h00,1'b0,1'b1,32'h42, 1'b0,1'b1,8'h00,1'b1};
        tbl[6]  = '{1'b1,1'b0,4'h0,4'h0,32'h0, 1'b0,8'h00,1'b0,1'b1,32'h43, 1'b0,1'b1,8'h00,1'b0};
        tbl[7]  = '{1'b1,1'b0,4'h0,4'h4,32'h0, 1'b0,8'h00,1'b0,1'b1,32'h0,  1'b0,1'b1,8'h00,1'b0};
        tbl[8]  = '{1'b1,1'b0,4'h0,4'h0,32'h0, 1'b0,8'h00,1'b0,1'b1,32'h0,  1'b0,1'b1,8'h00,1'b0};
        tbl[9]  = '{1'b1,1'b0,4'h0,4'h4,32'h0, 1'b0,8'h00,1'b0,1'b1,32'h0,  1'b0,1'b1,8'h00,1'b0};
        tbl[10] = '{1'b0,1'b1,4'h1,4'h8,32'h55,1'b0,8'h00,1'b0,1'b0,32'h0,  1'b1,1'b1,8'h55,1'b0};
        tbl[11] = '{1'b0,1'b1,4'h1,4'h8,32'h66,1'b0,8'h00,1'b0,1'b0,32'h0,  1'b1,1'b1,8'h55,1'b0};
        tbl[12] = '{1'b1,1'b0,4'h0,4'h4,32'h0, 1'b0,8'h00,1'b0,1'b1,32'h202,1'b1,1'b1,8'h55,1'b0};
        tbl[13] = '{1'b0,1'b1,4'h1,4'h8,32'h77,1'b0,8'h00,1'b1,1'b0,32'h0,  1'b1,1'b1,8'h77,1'b0};
        tbl[14] = '{1'b0,1'b0,4'h0,4'h0,32'h0, 1'b0,8'h00,1'b1,1'b0,32'h0,  1'b0,1'b0,8'h00,1'b0};
        tbl[15] = '{1'b0,1'b1,4'h0,4'h8,32'h88,1'b0,8'h00,1'b0,1'b0,32'h0,  1'b0,1'b0,8'h00,1'b0};
        tbl[16] = '{1'b1,1'b0,4'h0,4'h4,32'h0, 1'b0,8'h00,1'b0,1'b1,32'h200,1'b0,1'b0,8'h00,1'b0};
        tbl[17] = '{1'b0,1'b1,4'h1,4'hC,32'h2, 1'b0,8'h00,1'b0,1'b0,32'h0,  1'b0,1'b0,8'h00,1'b0};
        tbl[18] = '{1'b1,1'b0,4'h0,4'h4,32'h0, 1'b0,8'h00,1'b0,1'b1,32'h0,  1'b0,1'b0,8'h00,1'b0};
        tbl[19] = '{1'b1,1'b0,4'h0,4'h8,32'h0, 1'b0,8'h00,1'b0,1'b1,32'h0,  1'b0,1'b0,8'h00,1'b0};
        tbl[20] = '{1'b0,1'b1,4'hF,4'h0,32'hAB,1'b0,8'h00,1'b0,1'b0,32'h0,  1'b0,1'b0,8'h00,1'b0};
        tbl[21] = '{1'b1,1'b0,4'h0,4'h4,32'h0, 1'b0,8'h00,1'b0,1'b1,32'h0,  1'b0,1'b0,8'h00,1'b0};

        // Reset state
        idle();
        repeat (2) @(posedge iCLK);
        #1;
        chk("rst_rxReady", 32'(oRxReady), 32'h1);
        chk("rst_txValid", 32'(oTxValid), 32'h0);
        chk("rst_txData",  32'(oTxData),  32'h0);
        chk("rst_irq",     32'(oIrq),     32'h0);
        drive(1'b1, 1'b0, 4'h0, 4'h4, 32'h0, 1'b0, 8'h0, 1'b0);
        #1;
        chk("rst_status", bus.DwReadData, 32'h0);
        idle();
        @(negedge iCLK);
        iRST = 1'b1;
        tick();

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].rd, tbl[i].wr, tbl[i].be, tbl[i].off, tbl[i].wd,
                  tbl[i].rxV, tbl[i].rxD, tbl[i].txR);
            #1;
            if (tbl[i].chkRd) chk($sformatf("v%0d_rd", i), bus.DwReadData, tbl[i].expRd);
            tick();
            chk($sformatf("v%0d_txV", i), 32'(oTxValid), 32'(tbl[i].expTxV));
            if (tbl[i].chkTxD) chk($sformatf("v%0d_txD", i), 32'(oTxData), 32'(tbl[i].expTxD));
            chk($sformatf("v%0d_irq", i), 32'(oIrq), 32'(tbl[i].expIrq));
        end
        idle();

        // Fill to full, overflow, then push+pop while full
        for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i));
        idle();
        #1;
        chk("full_rxReady", 32'(oRxReady), 32'h0);
        readChk("full_status", 4'h4, 32'h41);
        push(8'h99);
        idle();
        readChk("ovf_status", 4'h4, 32'h141);
        drive(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 8'hAA, 1'b0);
        #1;
        chk("fullpp_rd", bus.DwReadData, 32'h10);
        tick();
        idle();
        #1;
        chk("fullpp_rxReady", 32'(oRxReady), 32'h0);
        readChk("fullpp_status", 4'h4, 32'h141);

        // Out-of-window and disabled reads must not drive or pop
        bus.DwReadEnable = 1'b1;
        bus.DwAddress    = BASE + 32'h10;
        #1;
        chkUndriven("oow_rd");
        tick();
        bus.DwReadEnable = 1'b0;
        bus.DwAddress    = BASE;
        #1;
        chkUndriven("noen_rd");
        tick();

        for (int i = 1; i < DEPTH; i++) readChk($sformatf("drain%0d", i), 4'h0, 32'(8'h10 + i));
        readChk("drain_tail", 4'h0, 32'hAA);
        readChk("drain_status", 4'h4, 32'h100);

        // Flush and sticky clear with 5 entries and both stickies set
        for (int i = 0; i < 5; i++) push(8'(8'h20 + i));
        drive(1'b0, 1'b1, 4'h1, 4'h8, 32'h31, 1'b0, 8'h0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 4'h1, 4'h8, 32'h32, 1'b0, 8'h0, 1'b0);
        tick();
        readChk("preflush_status", 4'h4, 32'h317);
        drive(1'b0, 1'b1, 4'h1, 4'hC, 32'h3, 1'b0, 8'h0, 1'b1);
        tick();
        idle();
        #1;
        chk("flush_irq", 32'(oIrq), 32'h0);
        chk("flush_rxReady", 32'(oRxReady), 32'h1);
        readChk("flush_status", 4'h4, 32'h0);
        readChk("flush_rd", 4'h0, 32'h0);

        // Asynchronous reset mid-cycle
        for (int i = 0; i < 4; i++) push(8'(8'h60 + i));
        drive(1'b0, 1'b1, 4'h1, 4'h8, 32'h5A, 1'b0, 8'h0, 1'b0);
        tick();
        idle();
        #1;
        chk("prerst_irq", 32'(oIrq), 32'h1);
        chk("prerst_txV", 32'(oTxValid), 32'h1);
        @(posedge iCLK);
        #3;
        iRST = 1'b0;
        #1;
        chk("arst_rxReady", 32'(oRxReady), 32'h1);
        chk("arst_txValid", 32'(oTxValid), 32'h0);
        chk("arst_txData",  32'(oTxData),  32'h0);
        chk("arst_irq",     32'(oIrq),     32'h0);
        @(negedge iCLK);
        iRST = 1'b1;
        push(8'h77);
        idle();
        readChk("postrst_status", 4'h4, 32'h5);
        readChk("postrst_rd", 4'h0, 32'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
